// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-port, synchronous-read memory between an instruction
// fetch master (m0) and a load/store master (m1). Arbitration is decided
// combinationally in the accept cycle. The response returns exactly one
// cycle later on the owner's rvalid/rdata. A new grant can overlap the
// previous response, so the port sustains one access per cycle.
//
// The data port (m1) normally wins contested cycles. A starvation counter
// lets m0 win once it has lost STARVE_MAX contested cycles in a row.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   m0_req_i/addr_i     fetch request, held until granted
//   m0_gnt_o            fetch accepted this cycle
//   m0_rvalid_o/rdata_o fetch response (one cycle after grant)
//   m1_req_i/we_i/addr_i/wdata_i/wstrb_i   data request, held until granted
//   m1_gnt_o            data request accepted this cycle
//   m1_rvalid_o/rdata_o read data / write acknowledge (rdata=0 for writes)
//   mem_req_o/we_o/addr_o/wdata_o/wstrb_o  memory access, driven by the winner
//   mem_rdata_i         memory read data, valid the cycle after mem_req_o
//   m0_starved_o        starvation counter is at STARVE_MAX
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,

    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic                m0_starved_o
);

    localparam int         STRB_W     = DATA_W / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_M0 = 2'd1,
        RESP_M1 = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic       resp_we_reg, resp_we_next;   // the m1 access in flight is a write
    logic [3:0] starve_cnt_reg, starve_cnt_next;

    logic       contested;
    logic       gnt0;
    logic       gnt1;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            resp_we_reg    <= 1'b0;
            starve_cnt_reg <= 4'd0;
        end else begin
            state_reg      <= state_next;
            resp_we_reg    <= resp_we_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Arbitration and next state.
    // The grants here are not qualified by reset: the registers are held
    // clear while rst is low, and the externally visible grants are masked
    // separately below.
    // -----------------------------------------------------------------------
    always_comb begin
        contested       = m0_req_i & m1_req_i;
        gnt0            = 1'b0;
        gnt1            = 1'b0;
        state_next      = IDLE;
        resp_we_next    = 1'b0;
        starve_cnt_next = starve_cnt_reg;

        if (contested) begin
            if (starve_cnt_reg == STARVE_LIM) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else if (m0_req_i) begin
            gnt0 = 1'b1;
        end else if (m1_req_i) begin
            gnt1 = 1'b1;
        end

        if (gnt0) begin
            state_next      = RESP_M0;
            starve_cnt_next = 4'd0;
        end else if (gnt1) begin
            state_next   = RESP_M1;
            resp_we_next = m1_we_i;
            // Only a contested loss counts against m0; saturate at the limit.
            if (contested && (starve_cnt_reg != STARVE_LIM)) begin
                starve_cnt_next = starve_cnt_reg + 4'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Grant and memory drive. Everything combinational is forced to zero
    // while reset is asserted so the memory never sees a stray access.
    // -----------------------------------------------------------------------
    assign m0_gnt_o  = rst & gnt0;
    assign m1_gnt_o  = rst & gnt1;
    assign mem_req_o = rst & (m0_req_i | m1_req_i);
    assign mem_we_o  = rst & gnt1 & m1_we_i;

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        if (rst) begin
            if (gnt1) begin
                mem_addr_o  = m1_addr_i;
                mem_wdata_o = m1_wdata_i;
                mem_wstrb_o = m1_wstrb_i[STRB_W-1:0];
            end else if (gnt0) begin
                mem_addr_o  = m0_addr_i;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response path: the owner sees mem_rdata_i, everybody else sees zero.
    // A write acknowledge carries zero data even though the memory output
    // is undefined for that cycle.
    // -----------------------------------------------------------------------
    assign m0_rvalid_o = (state_reg == RESP_M0);
    assign m1_rvalid_o = (state_reg == RESP_M1);
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    assign m1_rdata_o  = (m1_rvalid_o && !resp_we_reg) ? mem_rdata_i : '0;

    assign m0_starved_o = (starve_cnt_reg == STARVE_LIM);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i;
    logic [31:0] m0_addr_i;
    logic        m0_gnt_o, m0_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic        m1_req_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_wdata_i;
    logic [3:0]  m1_wstrb_i;
    logic        m1_gnt_o, m1_rvalid_o;
    logic [31:0] m1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i = 32'hBAD0_BAD0;
    logic        m0_starved_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rdata_i(mem_rdata_i), .m0_starved_o(m0_starved_o)
    );

    // Read-only memory contents seen by the bench; a few fixed instruction words.
    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: rom = 32'h0000_0013;
            32'h0000_0004: rom = 32'h0010_0093;
            32'h0000_0008: rom = 32'h0020_0113;
            default:       rom = {addr[15:0] ^ 16'h5A5A, addr[15:0]};
        endcase
    endfunction

    // Synchronous-read memory; junk data on writes and idle cycles.
    always_ff @(posedge clk) begin
        mem_rdata_i <= (mem_req_o && !mem_we_o) ? rom(mem_addr_o) : 32'hBAD0_BAD0;
    end

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] d0;
        logic [31:0] d1;
    } resp_t;

    resp_t q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    model_cnt = 0;
    int    cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, check combinational grant/memory drive
    // and the response owed by the previous cycle, then clock the model.
    task automatic step(input logic r0, input logic [31:0] a0,
                        input logic r1, input logic we, input logic [31:0] a1,
                        input logic [31:0] wd, input logic [3:0] ws);
        resp_t e;
        resp_t n;
        logic  g0, g1;
        m0_req_i   = r0;
        m0_addr_i  = a0;
        m1_req_i   = r1;
        m1_we_i    = we;
        m1_addr_i  = a1;
        m1_wdata_i = wd;
        m1_wstrb_i = ws;
        #1;
        if (q.size() > 0) e = q.pop_front();
        else e = '{v0: 1'b0, v1: 1'b0, d0: 32'h0, d1: 32'h0};
        chk("m0_rvalid", {31'h0, m0_rvalid_o}, {31'h0, e.v0});
        chk("m1_rvalid", {31'h0, m1_rvalid_o}, {31'h0, e.v1});
        chk("m0_rdata", m0_rdata_o, e.d0);
        chk("m1_rdata", m1_rdata_o, e.d1);

        g0 = r0 && (!r1 || model_cnt == SMAX);
        g1 = r1 && !g0;
        chk("starved", {31'h0, m0_starved_o}, {31'h0, model_cnt == SMAX});
        chk("m0_gnt", {31'h0, m0_gnt_o}, {31'h0, g0});
        chk("m1_gnt", {31'h0, m1_gnt_o}, {31'h0, g1});
        chk("mem_req", {31'h0, mem_req_o}, {31'h0, r0 | r1});
        chk("mem_we", {31'h0, mem_we_o}, {31'h0, g1 & we});
        chk("mem_addr", mem_addr_o, g1 ? a1 : (g0 ? a0 : 32'h0));
        chk("mem_wdata", mem_wdata_o, g1 ? wd : 32'h0);
        chk("mem_wstrb", {28'h0, mem_wstrb_o}, {28'h0, g1 ? ws : 4'h0});
        $display("cyc %0d req=%b%b g0=%b g1=%b addr=%h we=%b rv=%b%b",
                 cyc, r0, r1, m0_gnt_o, m1_gnt_o, mem_addr_o, mem_we_o,
                 m0_rvalid_o, m1_rvalid_o);

        n.v0 = g0;
        n.v1 = g1;
        n.d0 = g0 ? rom(a0) : 32'h0;
        n.d1 = (g1 && !we) ? rom(a1) : 32'h0;
        q.push_back(n);
        if (g0) model_cnt = 0;
        else if (r0 && r1 && model_cnt < SMAX) model_cnt++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        rst        = 1'b0;
        m0_req_i   = 1'b1;
        m0_addr_i  = 32'h10;
        m1_req_i   = 1'b1;
        m1_we_i    = 1'b1;
        m1_addr_i  = 32'h20;
        m1_wdata_i = 32'hFFFF_FFFF;
        m1_wstrb_i = 4'hF;
        @(negedge clk);
        #1;
        // Everything reads zero while reset is held, despite live requests.
        chk("rst_m0_gnt", {31'h0, m0_gnt_o}, 32'h0);
        chk("rst_m1_gnt", {31'h0, m1_gnt_o}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wstrb", {28'h0, mem_wstrb_o}, 32'h0);
        chk("rst_rvalid", {30'h0, m0_rvalid_o, m1_rvalid_o}, 32'h0);
        chk("rst_starved", {31'h0, m0_starved_o}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // First fetch right out of reset.
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        // Back-to-back fetches.
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle();
        // Partial write; acknowledge carries zero data.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011);
        idle();
        // Continuous contention: m1,m1,m1,m0 repeating.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0, 32'h300 + 32'(4 * i),
                 32'h1234_0000 + 32'(i), 4'hF);
        end
        idle();
        // Build the counter up to the limit, then reset after an m1 read grant.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h400, 1'b1, 1'b0, 32'h500 + 32'(4 * i), 32'h0, 4'h0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        rst = 1'b0;
        #1;
        chk("midrst_m1_rvalid", {31'h0, m1_rvalid_o}, 32'h0);
        chk("midrst_m1_rdata", m1_rdata_o, 32'h0);
        chk("midrst_starved", {31'h0, m0_starved_o}, 32'h0);
        q.delete();
        model_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // Counter was cleared: the first contested cycle goes to m1.
        step(1'b1, 32'h600, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
        idle();
        idle();

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {24'h1, 6'($urandom_range(0, 63)), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port, synchronous-read memory between two masters: instruction fetch (m0) and load/store (m1).
- Sits between the core and the memory in the SoC top. The memory can be the instruction ROM or a unified ROM/RAM.
- Provides per-master req/gnt/rvalid handshakes, fixed data-port priority, and an anti-starvation counter for the fetch port.
- Sustains one access per cycle.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; must be a multiple of 8.
- STARVE_MAX, 3, consecutive m0 losses after which m0 wins the next contested cycle; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- m0_req_i  in  1  fetch request; held with address until granted
- m0_addr_i  in  ADDR_W  fetch address
- m0_gnt_o  out  1  fetch accepted this cycle
- m0_rvalid_o  out  1  fetch data valid
- m0_rdata_o  out  DATA_W  fetch data
- m1_req_i  in  1  data request; held with we/addr/wdata/wstrb until granted
- m1_we_i  in  1  1=write, 0=read
- m1_addr_i  in  ADDR_W  data address
- m1_wdata_i  in  DATA_W  write data
- m1_wstrb_i  in  DATA_W/8  byte enables
- m1_gnt_o  out  1  data request accepted this cycle
- m1_rvalid_o  out  1  read data valid / write acknowledge
- m1_rdata_o  out  DATA_W  read data
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_wstrb_o  out  DATA_W/8  memory byte enables
- mem_rdata_i  in  DATA_W  memory read data, valid the cycle after mem_req_o
- m0_starved_o  out  1  starvation counter has reached STARVE_MAX

Behaviour:
- Reset (rst=0, asynchronous)
  - Clears owner register, rvalid register and starve counter.
  - All outputs read 0 while rst=0, including combinational gnt and mem_* outputs.
  - An access in flight when reset asserts is dropped; no rvalid is issued after release.
- Arbitration is combinational in the accept cycle.
  - Only m0 requests: m0 granted.
  - Only m1 requests: m1 granted.
  - Both request: m1 wins unless starve_cnt==STARVE_MAX, in which case m0 wins.
  - At most one gnt is high per cycle.
  - gnt is high exactly when mem_req_o is high.
- Memory drive
  - mem_req_o = m0_req_i | m1_req_i.
  - mem_addr_o, mem_we_o, mem_wdata_o and mem_wstrb_o come from the granted master.
  - When m0 is granted: mem_we_o=0, mem_wstrb_o=0, mem_wdata_o=0.
  - When idle: all mem_* outputs = 0.
- Response (state held in registers owner and rv)
  - Latency is exactly 1 cycle: rv and owner are registered on the grant edge.
  - Next cycle, the owner's rvalid=1 and its rdata=mem_rdata_i.
  - A write returns an rvalid pulse with rdata=0.
  - The non-owner rdata is 0.
- Pipelining
  - A new grant may be issued in the same cycle as the previous rvalid, so back-to-back accesses give one rvalid per cycle.
  - No backpressure on responses: masters must accept rvalid unconditionally.
- Starve counter (0..STARVE_MAX)
  - Increments, saturating, on each cycle where both request and m1 wins.
  - Clears on any m0 grant.
  - Holds otherwise.
  - m0_starved_o is high when starve_cnt==STARVE_MAX (registered value).
- States: IDLE (rv=0), RESP_M0 (rv=1, owner=0), RESP_M1 (rv=1, owner=1). Next state is set by this cycle's grant:
  - No grant -> IDLE.
  - m0 granted -> RESP_M0.
  - m1 granted -> RESP_M1.
- Request dropped without grant: legal; no side effects.

Test Plan:
- Reset release, m0_req_i=1, m0_addr_i=0x0000_0004, memory returns 0x0010_0093 -> m0_gnt_o=1 in cycle 0; m0_rvalid_o=1 and m0_rdata_o=0x0010_0093 in cycle 1; m1_rvalid_o=0.
- m0 fetches 0x0, 0x4, 0x8 back-to-back -> three gnts on consecutive cycles, three rvalids on consecutive cycles, data in order.
- m1 write addr=0x100, wdata=0xDEADBEEF, wstrb=4'b0011 -> mem_we_o=1 with wstrb=4'b0011 on the grant cycle; next cycle m1_rvalid_o=1 and m1_rdata_o=0.
- Both request continuously, STARVE_MAX=3 -> grant pattern m1,m1,m1,m0,m1,m1,m1,m0...; m0_starved_o high on each cycle m0 is granted.
- Assert rst low in the cycle after an m1 read grant -> m1_rvalid_o stays 0; after release starve_cnt=0 and the first contested cycle grants m1.
- m0 and m1 both idle -> mem_req_o=0, all mem_* outputs and gnts=0, state remains IDLE.
